// File: rtl/bcd_fib_pkg.sv
// Shared types, sizing helpers and default widths for the BCD Fibonacci unit
// and its sequential binary-to-BCD converter.
package bcd_fib_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BCD2BIN,
        S_FIB,
        S_BIN2BCD,
        S_DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int pow10(input int digits);
        int p;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return p;
    endfunction

    function automatic int max_result(input int out_digits);
        return pow10(out_digits) - 1;
    endfunction

    localparam int DEF_IN_DIGITS  = 2;
    localparam int DEF_OUT_DIGITS = 4;
    localparam int DEF_N_W        = clog2(pow10(DEF_IN_DIGITS));
    localparam int DEF_BIN_W      = clog2(pow10(DEF_OUT_DIGITS));
    localparam int MAX_RESULT     = max_result(DEF_OUT_DIGITS);
    // Wide enough to count down from the MS digit for up to three input digits.
    localparam int DIG_CNT_W      = 2;

endpackage

// File: rtl/bcd_fib_param_bin2bcd.sv
// Sequential double-dabble converter: BIN_W cycles from start_i to done_o,
// the first shift happens on the loading edge itself.
module bin2bcd_seq
    import bcd_fib_pkg::*;
#(
    parameter int BIN_W      = 14,
    parameter int OUT_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [BIN_W-1:0]        bin_i,
    output logic                    done_o,
    output logic [4*OUT_DIGITS-1:0] bcd_o
);
    localparam int CNT_W = clog2(BIN_W + 1);
    localparam int BCD_W = 4 * OUT_DIGITS;

    logic [BIN_W-1:0] sh_q, sh_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    genvar gi;
    generate
        for (gi = 0; gi < OUT_DIGITS; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                              : bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i) begin
            bcd_d  = {{(BCD_W-1){1'b0}}, bin_i[BIN_W-1]};
            sh_d   = bin_i << 1;
            cnt_d  = CNT_W'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = (adj << 1) | {{(BCD_W-1){1'b0}}, sh_q[BIN_W-1]};
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/bcd_fib_param.sv
// BCD index in, fib(n) out as BCD: digit-serial BCD->binary, iterative Fibonacci
// with early overflow exit, then sequential binary->BCD for the display path.
module bcd_fib_param
    import bcd_fib_pkg::*;
#(
    parameter int IN_DIGITS  = 2,
    parameter int OUT_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*IN_DIGITS-1:0]  bcd_in,
    output logic                    ready,
    output logic                    done,
    output logic                    overflow,
    output logic                    err_digit,
    output logic [4*OUT_DIGITS-1:0] bcd_out
);
    localparam int N_W   = clog2(pow10(IN_DIGITS));
    localparam int BIN_W = clog2(pow10(OUT_DIGITS));
    localparam int ACC_W = BIN_W + 1;
    localparam int LIMIT = max_result(OUT_DIGITS);
    localparam logic [4*OUT_DIGITS-1:0] ALL_NINES = {OUT_DIGITS{4'h9}};

    state_t                 state_q, state_d;
    logic [4*IN_DIGITS-1:0] bcd_in_q, bcd_in_d;
    logic [DIG_CNT_W-1:0]   dig_cnt_q, dig_cnt_d;
    logic [N_W-1:0]         n_bin_q, n_bin_d;
    logic [ACC_W-1:0]       t0_q, t0_d, t1_q, t1_d;
    logic                   ovf_pend_q, ovf_pend_d;
    logic                   err_pend_q, err_pend_d;
    logic [4*OUT_DIGITS-1:0] bcd_out_q;
    logic                   overflow_q, err_digit_q;

    logic [3:0]              digit;
    logic [ACC_W-1:0]        fib_sum;
    logic                    b2b_start, b2b_done;
    logic [BIN_W-1:0]        b2b_bin;
    logic [4*OUT_DIGITS-1:0] b2b_bcd;

    assign digit   = bcd_in_q[{dig_cnt_q, 2'b00} +: 4];
    assign fib_sum = t1_q + t0_q;

    always_comb begin
        state_d    = state_q;
        bcd_in_d   = bcd_in_q;
        dig_cnt_d  = dig_cnt_q;
        n_bin_d    = n_bin_q;
        t0_d       = t0_q;
        t1_d       = t1_q;
        ovf_pend_d = ovf_pend_q;
        err_pend_d = err_pend_q;
        b2b_start  = 1'b0;
        b2b_bin    = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bcd_in_d   = bcd_in;
                    ovf_pend_d = 1'b0;
                    err_pend_d = 1'b0;
                    dig_cnt_d  = DIG_CNT_W'(IN_DIGITS - 1);
                    n_bin_d    = '0;
                    t0_d       = '0;
                    t1_d       = ACC_W'(1);
                    state_d    = S_BCD2BIN;
                end
            end
            S_BCD2BIN: begin
                n_bin_d = N_W'(n_bin_q * 10 + digit);
                if (digit > 4'd9) err_pend_d = 1'b1;
                if (dig_cnt_q == '0) begin
                    state_d = err_pend_d ? S_DONE : S_FIB;
                end else begin
                    dig_cnt_d = dig_cnt_q - 1'b1;
                end
            end
            S_FIB: begin
                if (n_bin_q <= N_W'(1)) begin
                    b2b_start = 1'b1;
                    b2b_bin   = (n_bin_q == '0) ? '0 : t1_q[BIN_W-1:0];
                    state_d   = S_BIN2BCD;
                end else if (fib_sum > ACC_W'(LIMIT)) begin
                    // Stop as soon as the next term cannot be displayed.
                    ovf_pend_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    t1_d    = fib_sum;
                    t0_d    = t1_q;
                    n_bin_d = n_bin_q - 1'b1;
                end
            end
            S_BIN2BCD: begin
                if (b2b_done) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bcd_in_q    <= '0;
            dig_cnt_q   <= '0;
            n_bin_q     <= '0;
            t0_q        <= '0;
            t1_q        <= '0;
            ovf_pend_q  <= 1'b0;
            err_pend_q  <= 1'b0;
            bcd_out_q   <= '0;
            overflow_q  <= 1'b0;
            err_digit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcd_in_q   <= bcd_in_d;
            dig_cnt_q  <= dig_cnt_d;
            n_bin_q    <= n_bin_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            ovf_pend_q <= ovf_pend_d;
            err_pend_q <= err_pend_d;
            // Visible results move only on entry to DONE so the display never glitches.
            if (state_d == S_DONE && state_q != S_DONE) begin
                bcd_out_q   <= (ovf_pend_d || err_pend_d) ? ALL_NINES : b2b_bcd;
                overflow_q  <= ovf_pend_d;
                err_digit_q <= err_pend_d;
            end
        end
    end

    bin2bcd_seq #(
        .BIN_W      (BIN_W),
        .OUT_DIGITS (OUT_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (b2b_start),
        .bin_i   (b2b_bin),
        .done_o  (b2b_done),
        .bcd_o   (b2b_bcd)
    );

    assign ready     = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign overflow  = overflow_q;
    assign err_digit = err_digit_q;
    assign bcd_out   = bcd_out_q;

endmodule

// File: tb/tb_bcd_fib_param.sv
// Randomised and directed checks of bcd_fib_param (2/4 and 3/6 digit builds)
// against a plain-arithmetic Fibonacci/BCD reference.
module tb_bcd_fib_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0;
    logic [7:0]  bcd_in1 = '0;
    logic        ready1, done1, ovf1, err1;
    logic [15:0] out1;
    logic        start2 = 1'b0;
    logic [11:0] bcd_in2 = '0;
    logic        ready2, done2, ovf2, err2;
    logic [23:0] out2;

    int errors = 0;
    int checks = 0;

    localparam int BW1 = $clog2(10000);
    localparam int BW2 = $clog2(1000000);

    always #5 clk = ~clk;

    bcd_fib_param #(.IN_DIGITS(2), .OUT_DIGITS(4)) dut (
        .clk(clk), .reset(reset), .start(start1), .bcd_in(bcd_in1),
        .ready(ready1), .done(done1), .overflow(ovf1), .err_digit(err1), .bcd_out(out1)
    );

    bcd_fib_param #(.IN_DIGITS(3), .OUT_DIGITS(6)) dut_wide (
        .clk(clk), .reset(reset), .start(start2), .bcd_in(bcd_in2),
        .ready(ready2), .done(done2), .overflow(ovf2), .err_digit(err2), .bcd_out(out2)
    );

    // Reference: decimal index from digits, fib by iteration, decimal digits by %10.
    function automatic void model(input int in_d, input int out_d, input logic [23:0] bcd,
                                  output logic [23:0] exp_out, output logic exp_ovf,
                                  output logic exp_err, output int n);
        longint f0, f1, tmp, lim, v;
        lim = 1;
        for (int d = 0; d < out_d; d++) lim = lim * 10;
        lim = lim - 1;
        exp_err = 1'b0;
        n = 0;
        for (int d = in_d - 1; d >= 0; d--) begin
            int dig;
            dig = int'((bcd >> (4 * d)) & 24'hF);
            if (dig > 9) exp_err = 1'b1;
            n = n * 10 + dig;
        end
        f0 = 0;
        f1 = 1;
        for (int i = 0; i < n; i++) begin
            if (f0 > lim) break;
            tmp = f0 + f1;
            f0 = f1;
            f1 = tmp;
        end
        exp_ovf = !exp_err && (f0 > lim);
        exp_out = '0;
        v = f0;
        for (int d = 0; d < out_d; d++) begin
            exp_out[4*d +: 4] = (exp_err || exp_ovf) ? 4'd9 : 4'(v % 10);
            v = v / 10;
        end
    endfunction

    task automatic do_op(input bit wide, input logic [23:0] bcd, output logic [23:0] out,
                         output logic ovf, output logic err, output int lat,
                         output bit to, output bit unstable);
        logic [23:0] prev;
        int guard;
        to = 1'b0;
        unstable = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!(wide ? ready2 : ready1) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        prev = wide ? out2 : {8'h00, out1};
        if (wide) begin bcd_in2 = bcd[11:0]; start2 = 1'b1; end
        else begin bcd_in1 = bcd[7:0]; start1 = 1'b1; end
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        lat = 1;
        while (!(wide ? done2 : done1)) begin
            if ((wide ? out2 : {8'h00, out1}) !== prev) unstable = 1'b1;
            if (lat >= 300) begin to = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
        end
        out = wide ? out2 : {8'h00, out1};
        ovf = wide ? ovf2 : ovf1;
        err = wide ? err2 : err1;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done1); end
        checks++; if ({ovf1, err1} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {ovf1, err1}); end
        checks++; if (out1 !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", out1); end
        checks++; if (ready2 !== 1'b1 || out2 !== 24'h0) begin errors++; $display("FAIL reset_wide: got ready=%b out=%h expected 1/000000", ready2, out2); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_checked(input bit wide, input logic [23:0] bcd, input string tag);
        logic [23:0] out, eo;
        logic ovf, err, eovf, eerr;
        int lat, n, in_d, normal;
        bit to, unst;
        in_d = wide ? 3 : 2;
        model(in_d, wide ? 6 : 4, bcd, eo, eovf, eerr, n);
        normal = in_d + ((n < 1) ? 1 : n) + (wide ? BW2 : BW1) + 1;
        do_op(wide, bcd, out, ovf, err, lat, to, unst);
        $display("op %s bcd_in=%h n=%0d bcd_out=%h ovf=%b err=%b latency=%0d", tag, bcd, n, out, ovf, err, lat);
        checks++; if (to) begin errors++; $display("FAIL %s_timeout bcd_in=%h: done not seen in %0d cycles", tag, bcd, lat); end
        checks++; if (out !== eo) begin errors++; $display("FAIL %s_out bcd_in=%h: got %h expected %h", tag, bcd, out, eo); end
        checks++; if ({ovf, err} !== {eovf, eerr}) begin errors++; $display("FAIL %s_flags bcd_in=%h: got ovf/err %b%b expected %b%b", tag, bcd, ovf, err, eovf, eerr); end
        checks++; if (unst) begin errors++; $display("FAIL %s_stable bcd_in=%h: bcd_out changed before done, got 1 expected 0", tag, bcd); end
        checks++;
        if (eerr) begin
            if (lat != in_d + 1) begin errors++; $display("FAIL %s_lat bcd_in=%h: got %0d expected %0d", tag, bcd, lat, in_d + 1); end
        end else if (eovf) begin
            if (lat >= normal) begin errors++; $display("FAIL %s_lat bcd_in=%h: got %0d expected below %0d", tag, bcd, lat, normal); end
        end else if (lat != normal) begin
            errors++; $display("FAIL %s_lat bcd_in=%h: got %0d expected %0d", tag, bcd, lat, normal);
        end
    endtask

    task automatic test_directed;
        logic [7:0] tab [9];
        tab = '{8'h10, 8'h00, 8'h01, 8'h20, 8'h21, 8'h99, 8'h1A, 8'h05, 8'hA3};
        for (int i = 0; i < 9; i++) run_checked(1'b0, {16'h0, tab[i]}, "dir");
    endtask

    task automatic test_random;
        logic [7:0] b;
        for (int i = 0; i < 30; i++) begin
            b[7:4] = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 2));
            b[3:0] = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            run_checked(1'b0, {16'h0, b}, "rnd");
        end
    endtask

    task automatic test_busy_start;
        int lat, pulses;
        bit saw_ready;
        lat = 0;
        @(negedge clk);
        while (!ready1 && lat < 50) begin @(negedge clk); lat++; end
        bcd_in1 = 8'h15;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 1;
        saw_ready = 1'b0;
        while (!done1 && lat < 300) begin
            if (ready1) saw_ready = 1'b1;
            @(negedge clk);
            start1 = (lat == 6);
            if (lat == 6) bcd_in1 = 8'h03;
            @(posedge clk); #1;
            lat++;
        end
        start1 = 1'b0;
        $display("op busy bcd_in=15 bcd_out=%h latency=%0d", out1, lat);
        checks++; if (out1 !== 16'h0610) begin errors++; $display("FAIL busy_out: got %h expected 0610", out1); end
        checks++; if (lat != 2 + 15 + BW1 + 1) begin errors++; $display("FAIL busy_lat: got %0d expected %0d", lat, 2 + 15 + BW1 + 1); end
        checks++; if (saw_ready) begin errors++; $display("FAIL busy_ready: got ready high mid-operation, expected low"); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done1) pulses++;
        end
        checks++; if (pulses != 0 || ready1 !== 1'b1) begin errors++; $display("FAIL busy_queued: got %0d extra done pulses ready=%b expected 0/1", pulses, ready1); end
    endtask

    task automatic test_reset_mid;
        int lat, pulses;
        @(negedge clk);
        bcd_in1 = 8'h10;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 1;
        while (lat < 20) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        $display("op reset_mid bcd_out=%h ready=%b done=%b", out1, ready1, done1);
        checks++; if (ready1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL rstmid_state: got ready=%b done=%b expected 1/0", ready1, done1); end
        checks++; if (out1 !== 16'h0000 || {ovf1, err1} !== 2'b00) begin errors++; $display("FAIL rstmid_out: got %h flags %b%b expected 0000 00", out1, ovf1, err1); end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_done: got %0d done pulses expected 0", pulses); end
        run_checked(1'b0, 24'h07, "recover");
    endtask

    task automatic test_wide;
        logic [11:0] tab [4];
        logic [11:0] b;
        tab = '{12'h030, 12'h031, 12'h000, 12'h025};
        for (int i = 0; i < 4; i++) run_checked(1'b1, {12'h0, tab[i]}, "wide");
        for (int i = 0; i < 8; i++) begin
            b[11:8] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 9)) : 4'd0;
            b[7:4]  = 4'($urandom_range(0, 3));
            b[3:0]  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            run_checked(1'b1, {12'h0, b}, "wrnd");
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        test_reset;
        test_directed;
        test_random;
        test_busy_start;
        test_reset_mid;
        test_wide;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
